// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n
// Registered N-way arbiter with selectable fixed-priority or round-robin policy.
// A grant is locked until the owner pulses ack. A one-cycle RELEASE bubble
// follows every grant. All outputs come straight from flops.

module priority_arbiter_n #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          rr_mode,
    input  logic          ack,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [IW-1:0] fixed_win_s;
    logic [IW-1:0] rr_win_s;
    logic [IW-1:0] win_s;

    // Lowest set index of r; bit 0 has the highest priority.
    function automatic logic [IW-1:0] fixed_pick(input logic [N-1:0] r);
        logic [IW-1:0] w;
        w = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i]) begin
                w = IW'(i);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // First set index scanning p, p+1, ..., N-1, 0, ..., p-1.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [IW-1:0] p);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(p) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Pointer successor with explicit wrap so it never reaches N when N is
    // not a power of two.
    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] w);
        logic [IW-1:0] n;
        if (w == IW'(N - 1)) begin
            n = '0;
        end else begin
            n = w + IW'(1);
        end
        return n;
    endfunction

    // Winner candidates for both policies; the policy mux picks one.
    always_comb begin
        fixed_win_s = fixed_pick(req);
        rr_win_s    = rr_pick(req, ptr_q);
        if (rr_mode) begin
            win_s = rr_win_s;
        end else begin
            win_s = fixed_win_s;
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT/RELEASE lock FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d     = ST_GRANT;
                    gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_s;
                    gnt_idx_d   = win_s;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    ptr_d       = ptr_next(win_s);
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    state_d     = ST_RELEASE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    state_d     = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
                busy_d      = 1'b0;
                ptr_d       = '0;
            end
        endcase
    end

    // State, output and pointer registers; reset drops any held lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Scoreboard bench for priority_arbiter_n (N = 4): stimulus pushes expected
// grants, a negedge monitor pops one per new grant and checks it.

module tb_priority_arbiter_n;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          rr_mode;
    logic          ack;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;
    logic          busy;

    typedef struct {
        int idx;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   cyc;

    priority_arbiter_n #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rr_mode   (rr_mode),
        .ack       (ack),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests = tests + 1;
        if (act !== expv) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_gnt"}, 32'(gnt), 32'd0);
        chk({name, "_idx"}, 32'(gnt_idx), 32'd0);
        chk({name, "_valid"}, 32'(gnt_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_grant(input int idx, input int gap);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: every rising edge of gnt_valid is one grant event.
    initial begin
        logic prev_valid;
        int   last_cyc;
        exp_t e;
        prev_valid = 1'b0;
        last_cyc   = 0;
        forever begin
            @(negedge clk);
            if (gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("FAIL unexpected_grant: got idx %0d expected no grant", gnt_idx);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_idx", 32'(gnt_idx), 32'(e.idx));
                    chk("sb_gnt", 32'(gnt), 32'd1 << e.idx);
                    chk("sb_busy", 32'(busy), 32'd1);
                    if (e.gap > 0) begin
                        chk("sb_gap", 32'(cyc - last_cyc), 32'(e.gap));
                    end
                end
                last_cyc = cyc;
            end
            prev_valid = gnt_valid;
        end
    end

    // Releases the current grant with a single-cycle ack, then drains to IDLE.
    task automatic release_grant();
        ack = 1'b1;
        @(negedge clk);
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_busy", 32'(busy), 32'd1);
        ack = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rel_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        req     = 4'b1111;
        rr_mode = 1'b0;
        ack     = 1'b0;

        // Reset held two cycles with all requests up.
        repeat (2) begin
            @(negedge clk);
            chk_idle("reset");
        end
        rst = 1'b0;
        req = 4'b0000;
        repeat (2) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // Fixed priority: 1010 -> index 1, one cycle latency.
        expect_grant(1, 0);
        req = 4'b1010;
        @(negedge clk);
        chk("fix_latency", 32'(gnt_valid), 32'd1);
        ack = 1'b1;
        @(negedge clk);
        chk("fix_rel_gnt", 32'(gnt), 32'd0);
        chk("fix_rel_busy", 32'(busy), 32'd1);
        ack = 1'b0;
        expect_grant(1, 3);
        @(negedge clk);
        chk("fix_bubble_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("fix_regrant", 32'(gnt), 32'd2);
        release_grant();

        // Round-robin from a cleared pointer, ack held high: 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rr_reset");
        rst     = 1'b0;
        rr_mode = 1'b1;
        req     = 4'b1111;
        ack     = 1'b1;
        expect_grant(0, 0);
        expect_grant(1, 3);
        expect_grant(2, 3);
        expect_grant(3, 3);
        expect_grant(0, 3);
        repeat (13) @(negedge clk);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        ack = 1'b0;
        chk_idle("rr_done");

        // Lock hold (ptr = 1): grant 2, then owner drops and req[0] rises.
        expect_grant(2, 0);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0001;
        repeat (3) begin
            @(negedge clk);
            chk("lock_hold", 32'(gnt), 32'd4);
        end
        release_grant();

        // Set ptr to 1 via a fixed grant of index 0, then rr skip to 3.
        rr_mode = 1'b0;
        expect_grant(0, 0);
        req = 4'b0001;
        @(negedge clk);
        release_grant();
        rr_mode = 1'b1;
        expect_grant(3, 0);
        req = 4'b1001;
        @(negedge clk);
        chk("rr_skip_idx", 32'(gnt_idx), 32'd3);
        release_grant();
        expect_grant(0, 0);
        req = 4'b1001;
        @(negedge clk);
        chk("rr_wrap_idx", 32'(gnt_idx), 32'd0);
        release_grant();

        // Mid-grant reset (ptr = 1 -> grant 2, ptr becomes 3), no ack.
        expect_grant(2, 0);
        req = 4'b0100;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        rst = 1'b0;
        req = 4'b1111;
        expect_grant(0, 0);
        @(negedge clk);
        chk("post_reset_idx", 32'(gnt_idx), 32'd0);
        release_grant();

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
